// File: rtl/maxpool_pkg.sv
// maxpool_pkg -- shared types for the 2x2/stride-2 max-pooling stream.
//   state_e : frame FSM states (IDLE, RUN, FLUSH)
//   pixel_t : CH*DW packed pixel at the default layer configuration
//   chmax2  : per-channel signed max of two pixel_t values
// Optional build macro used by the pooling block: MAXPOOL_RELU_EN.
package maxpool_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam int PIX_CH = 8;
  localparam int PIX_DW = 16;

  typedef logic [PIX_CH*PIX_DW-1:0] pixel_t;

  // Independent signed compare per channel; ties return the shared value.
  function automatic pixel_t chmax2(input pixel_t a, input pixel_t b);
    pixel_t r;
    r = '0;
    for (int k = 0; k < PIX_CH; k++) begin
      r[k*PIX_DW +: PIX_DW] =
        ($signed(a[k*PIX_DW +: PIX_DW]) >= $signed(b[k*PIX_DW +: PIX_DW])) ?
        a[k*PIX_DW +: PIX_DW] : b[k*PIX_DW +: PIX_DW];
    end
    return r;
  endfunction

endpackage

// File: rtl/maxpool_linebuf.sv
// maxpool_linebuf -- register array holding one pooled row of pair maxima.
//   clk     : clock (array has no reset; contents are don't-care after reset)
//   we_i    : write enable
//   widx_i  : write word index
//   wdata_i : write data (one pixel)
//   ridx_i  : read word index
//   rdata_o : asynchronous read data
module maxpool_linebuf #(
  parameter int DEPTH = 13,
  parameter int W     = 128,
  parameter int IW    = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [IW-1:0] widx_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [IW-1:0] ridx_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[widx_i] <= wdata_i;
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream -- streaming 2x2/stride-2 max-pool over a raster-scan
// IMG_H x IMG_W feature map of CH signed DW-bit channels per pixel.
//   clk, rst           : clock, asynchronous active-high reset
//   start              : frame start pulse (accepted only in IDLE)
//   in_valid/in_ready  : input pixel handshake; in_data channel k at [k*DW +: DW]
//   out_valid/out_ready: pooled pixel handshake; out_data same packing
//   out_row, out_col   : pooled pixel address
//   busy               : frame in progress
//   done               : one-cycle pulse when the frame's last result leaves
// Build macro MAXPOOL_RELU_EN: when defined, negative output channels clamp to 0.
module maxpool2x2_stream
  import maxpool_pkg::*;
#(
  parameter int CH    = 8,
  parameter int DW    = 16,
  parameter int IMG_W = 26,
  parameter int IMG_H = 26,
  parameter int AW    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CH*DW-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH*DW-1:0] out_data,
  output logic [AW-1:0]   out_row,
  output logic [AW-1:0]   out_col,
  output logic            busy,
  output logic            done
);

  localparam int PW    = CH * DW;
  localparam int LB_D  = IMG_W / 2;
  localparam int LB_IW = (LB_D > 1) ? $clog2(LB_D) : 1;

  // Pixels at or beyond these bounds fall outside any full 2x2 window.
  localparam logic [AW-1:0] P2     = AW'(2 * (IMG_W / 2));
  localparam logic [AW-1:0] R2     = AW'(2 * (IMG_H / 2));
  localparam logic [AW-1:0] LAST_C = AW'(IMG_W - 1);
  localparam logic [AW-1:0] LAST_R = AW'(IMG_H - 1);

  typedef logic [PW-1:0] pix_t;

  function automatic pix_t pmax(input pix_t a, input pix_t b);
    pix_t r;
    r = '0;
    for (int k = 0; k < CH; k++) begin
      r[k*DW +: DW] = ($signed(a[k*DW +: DW]) >= $signed(b[k*DW +: DW])) ?
                      a[k*DW +: DW] : b[k*DW +: DW];
    end
    return r;
  endfunction

`ifdef MAXPOOL_RELU_EN
  function automatic pix_t relu(input pix_t p);
    pix_t r;
    r = p;
    for (int k = 0; k < CH; k++) begin
      if (p[k*DW + DW - 1]) r[k*DW +: DW] = '0;
    end
    return r;
  endfunction
`endif

  state_e          state_q, state_d;
  logic [AW-1:0]   col_q, col_d, row_q, row_d;
  pix_t            hold_q, hold_d;
  logic            ovalid_q, ovalid_d;
  pix_t            odata_q, odata_d;
  logic [AW-1:0]   orow_q, orow_d, ocol_q, ocol_d;

  logic            out_free, xfer, last_px, in_win, lb_we;
  logic [LB_IW-1:0] lb_idx;
  pix_t            lb_rdata, pair_max, quad_max, result;

  // Holding off input while a result is stuck guarantees a single output
  // register is enough: a new result can only land when the old one leaves.
  assign out_free = !ovalid_q || out_ready;
  assign in_ready = (state_q == RUN) && out_free;
  assign xfer     = in_valid && in_ready;
  assign last_px  = (row_q == LAST_R) && (col_q == LAST_C);
  assign in_win   = (col_q < P2) && (row_q < R2);
  assign lb_idx   = LB_IW'(col_q >> 1);

  assign pair_max = pmax(hold_q, in_data);
  assign quad_max = pmax(lb_rdata, pair_max);
`ifdef MAXPOOL_RELU_EN
  assign result   = relu(quad_max);
`else
  assign result   = quad_max;
`endif

  // Even rows store the horizontal pair max; odd rows consume it.
  assign lb_we = xfer && in_win && col_q[0] && !row_q[0];

  maxpool_linebuf #(
    .DEPTH (LB_D),
    .W     (PW),
    .IW    (LB_IW)
  ) u_linebuf (
    .clk     (clk),
    .we_i    (lb_we),
    .widx_i  (lb_idx),
    .wdata_i (pair_max),
    .ridx_i  (lb_idx),
    .rdata_o (lb_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN:   if (xfer && last_px) state_d = FLUSH;
      FLUSH: if (out_free) begin
        state_d = IDLE;
        done    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    hold_d   = hold_q;
    ovalid_d = ovalid_q && !out_ready;
    odata_d  = odata_q;
    orow_d   = orow_q;
    ocol_d   = ocol_q;
    if (xfer) begin
      if (col_q == LAST_C) begin
        col_d = '0;
        row_d = (row_q == LAST_R) ? '0 : row_q + AW'(1);
      end else begin
        col_d = col_q + AW'(1);
      end
      if (in_win && !col_q[0]) hold_d = in_data;
      if (in_win && col_q[0] && row_q[0]) begin
        odata_d  = result;
        orow_d   = row_q >> 1;
        ocol_d   = col_q >> 1;
        ovalid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q    <= '0;
      row_q    <= '0;
      hold_q   <= '0;
      ovalid_q <= 1'b0;
      odata_q  <= '0;
      orow_q   <= '0;
      ocol_q   <= '0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      hold_q   <= hold_d;
      ovalid_q <= ovalid_d;
      odata_q  <= odata_d;
      orow_q   <= orow_d;
      ocol_q   <= ocol_d;
    end
  end

  assign out_valid = ovalid_q;
  assign out_data  = odata_q;
  assign out_row   = orow_q;
  assign out_col   = ocol_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
module tb_maxpool2x2_stream;
  localparam int AW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, in_valid, out_ready;
  logic [127:0] din;
  int           sel;

  // Three layer geometries share stimulus; sel picks which one is live.
  logic         ov4, ir4, bz4, dn4;  logic [31:0]  od4;  logic [AW-1:0] or4, oc4;
  logic         ov5, ir5, bz5, dn5;  logic [127:0] od5;  logic [AW-1:0] or5, oc5;
  logic         ov26, ir26, bz26, dn26; logic [127:0] od26; logic [AW-1:0] or26, oc26;

  maxpool2x2_stream #(.CH(2), .DW(16), .IMG_W(4), .IMG_H(4), .AW(AW)) u4 (
    .clk(clk), .rst(rst), .start(start && sel == 0), .in_valid(in_valid && sel == 0),
    .in_ready(ir4), .in_data(din[31:0]), .out_valid(ov4), .out_ready(out_ready),
    .out_data(od4), .out_row(or4), .out_col(oc4), .busy(bz4), .done(dn4));

  maxpool2x2_stream #(.CH(8), .DW(16), .IMG_W(5), .IMG_H(5), .AW(AW)) u5 (
    .clk(clk), .rst(rst), .start(start && sel == 1), .in_valid(in_valid && sel == 1),
    .in_ready(ir5), .in_data(din), .out_valid(ov5), .out_ready(out_ready),
    .out_data(od5), .out_row(or5), .out_col(oc5), .busy(bz5), .done(dn5));

  maxpool2x2_stream #(.CH(8), .DW(16), .IMG_W(26), .IMG_H(26), .AW(AW)) u26 (
    .clk(clk), .rst(rst), .start(start && sel == 2), .in_valid(in_valid && sel == 2),
    .in_ready(ir26), .in_data(din), .out_valid(ov26), .out_ready(out_ready),
    .out_data(od26), .out_row(or26), .out_col(oc26), .busy(bz26), .done(dn26));

  logic ov, iready, bsy, dn;
  logic [127:0] od;
  logic [AW-1:0] orow, ocol;

  always_comb begin
    ov = ov26; iready = ir26; bsy = bz26; dn = dn26; od = od26; orow = or26; ocol = oc26;
    if (sel == 0) begin
      ov = ov4; iready = ir4; bsy = bz4; dn = dn4; od = {96'b0, od4}; orow = or4; ocol = oc4;
    end else if (sel == 1) begin
      ov = ov5; iready = ir5; bsy = bz5; dn = dn5; od = od5; orow = or5; ocol = oc5;
    end
  end

  typedef struct { int r; int c; logic [127:0] d; } res_t;
  res_t got_q[$], exp_q[$];
  logic [127:0] frame [0:675];
  int checks = 0, failures = 0, done_cnt = 0;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (ov && out_ready) got_q.push_back('{int'(orow), int'(ocol), od});
      if (dn) done_cnt++;
    end
  end

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; din = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic fill_random(input int w, input int h, input int ch);
    for (int i = 0; i < w*h; i++) begin
      frame[i] = '0;
      for (int k = 0; k < ch; k++) frame[i][k*16 +: 16] = 16'($urandom);
    end
  endtask

  // Reference: every full 2x2 window in raster order, per-channel signed max.
  task automatic build_expected(input int w, input int h, input int ch);
    logic [127:0] d;
    logic signed [15:0] s;
    int m, v;
    exp_q.delete();
    for (int r = 0; r < h/2; r++)
      for (int c = 0; c < w/2; c++) begin
        d = '0;
        for (int k = 0; k < ch; k++) begin
          m = -100000;
          for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
              s = frame[(2*r+dy)*w + 2*c+dx][k*16 +: 16];
              v = s;
              if (v > m) m = v;
            end
`ifdef MAXPOOL_RELU_EN
          if (m < 0) m = 0;
`endif
          d[k*16 +: 16] = 16'(m);
        end
        exp_q.push_back('{r, c, d});
      end
  endtask

  task automatic start_frame();
    got_q.delete(); done_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic feed(input int n, input int gap, output bit ok);
    bit acc;
    int cyc;
    ok = 1'b1;
    for (int i = 0; i < n && ok; i++) begin
      while ($urandom_range(99) < gap) begin in_valid = 1'b0; @(posedge clk); #1; end
      in_valid = 1'b1; din = frame[i];
      acc = 1'b0; cyc = 0;
      while (!acc && cyc < 200) begin
        @(negedge clk); acc = iready;
        @(posedge clk); #1; cyc++;
      end
      if (!acc) ok = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (!bsy) ok = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      checks++;
      if ({ov, iready, bsy, dn, orow, ocol, od} !== '0) begin
        failures++;
        $display("FAIL reset_state inst=%0d got ov=%b ir=%b busy=%b done=%b row=%0d col=%0d data=%h want all zero",
                 s, ov, iready, bsy, dn, orow, ocol, od);
      end
    end
  endtask

  task automatic test_ramp4x4();
    bit ok, idle;
    int rr[4] = '{0, 0, 1, 1};
    int cc[4] = '{0, 1, 0, 1};
    int vv[4] = '{5, 7, 13, 15};
    logic [31:0] want;
    sel = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) frame[r*4+c] = {96'b0, 16'(r*4+c), 16'(r*4+c)};
    start_frame();
    feed(16, 0, ok);
    wait_idle(50, idle);
    checks++;
    if (!ok || !idle) begin failures++; $display("FAIL ramp_timeout fed=%b idle=%b want 1 1", ok, idle); end
    checks++;
    if (got_q.size() != 4) begin failures++; $display("FAIL ramp_count got=%0d want=4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      want = {16'(vv[i]), 16'(vv[i])};
      checks++;
      if (got_q[i].r !== rr[i] || got_q[i].c !== cc[i] || got_q[i].d[31:0] !== want) begin
        failures++;
        $display("FAIL ramp_out i=%0d got (%0d,%0d)=%h want (%0d,%0d)=%h",
                 i, got_q[i].r, got_q[i].c, got_q[i].d[31:0], rr[i], cc[i], want);
      end
    end
    checks++;
    if (done_cnt != 1 || bsy !== 1'b0) begin
      failures++; $display("FAIL ramp_done done_pulses=%0d busy=%b want 1 0", done_cnt, bsy);
    end
  endtask

  task automatic test_neg_window();
    bit ok, idle;
    logic [15:0] want0;
    sel = 0;
    fill_random(4, 4, 2);
    frame[0][15:0] = -16'sd3; frame[1][15:0] = -16'sd1;
    frame[4][15:0] = -16'sd7; frame[5][15:0] = -16'sd2;
`ifdef MAXPOOL_RELU_EN
    want0 = 16'd0;
`else
    want0 = 16'hFFFF;
`endif
    build_expected(4, 4, 2);
    start_frame();
    feed(16, 20, ok);
    wait_idle(100, idle);
    checks++;
    if (got_q.size() != 4 || !ok || !idle) begin
      failures++; $display("FAIL neg_count got=%0d fed=%b idle=%b want 4 1 1", got_q.size(), ok, idle);
    end
    if (got_q.size() > 0) begin
      checks++;
      if (got_q[0].d[15:0] !== want0) begin
        failures++; $display("FAIL neg_window got=%h want=%h", got_q[0].d[15:0], want0);
      end
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].r !== exp_q[i].r || got_q[i].c !== exp_q[i].c || got_q[i].d !== exp_q[i].d) begin
        failures++;
        $display("FAIL neg_frame i=%0d got (%0d,%0d,%h) want (%0d,%0d,%h)", i,
                 got_q[i].r, got_q[i].c, got_q[i].d, exp_q[i].r, exp_q[i].c, exp_q[i].d);
      end
    end
  endtask

  task automatic test_odd_dims();
    bit ok, idle;
    sel = 1;
    fill_random(5, 5, 8);
    build_expected(5, 5, 8);
    start_frame();
    feed(25, 0, ok);
    checks++;
    if (!ok || done_cnt != 0) begin
      failures++; $display("FAIL odd_early fed=%b done_pulses=%0d want 1 0", ok, done_cnt);
    end
    wait_idle(20, idle);
    checks++;
    if (!idle || done_cnt != 1 || got_q.size() != 4) begin
      failures++;
      $display("FAIL odd_end idle=%b done_pulses=%0d outputs=%0d want 1 1 4", idle, done_cnt, got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].r !== exp_q[i].r || got_q[i].c !== exp_q[i].c || got_q[i].d !== exp_q[i].d) begin
        failures++;
        $display("FAIL odd_frame i=%0d got (%0d,%0d,%h) want (%0d,%0d,%h)", i,
                 got_q[i].r, got_q[i].c, got_q[i].d, exp_q[i].r, exp_q[i].c, exp_q[i].d);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok, idle, seen;
    logic [127:0] cap;
    sel = 0;
    fill_random(4, 4, 2);
    build_expected(4, 4, 2);
    out_ready = 1'b0;
    start_frame();
    fork
      feed(16, 0, ok);
      begin
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin @(negedge clk); seen = ov; end
        cap = od;
        checks++;
        if (!seen || cap !== exp_q[0].d) begin
          failures++; $display("FAIL bp_first seen=%b got=%h want=%h", seen, cap, exp_q[0].d);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
          checks++;
          if (ov !== 1'b1 || od !== cap || iready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold cyc=%0d got ov=%b ir=%b data=%h want ov=1 ir=0 data=%h", i, ov, iready, od, cap);
          end
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_idle(100, idle);
    checks++;
    if (!ok || !idle || got_q.size() != 4) begin
      failures++; $display("FAIL bp_count fed=%b idle=%b outputs=%0d want 1 1 4", ok, idle, got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].r !== exp_q[i].r || got_q[i].c !== exp_q[i].c || got_q[i].d !== exp_q[i].d) begin
        failures++;
        $display("FAIL bp_frame i=%0d got (%0d,%0d,%h) want (%0d,%0d,%h)", i,
                 got_q[i].r, got_q[i].c, got_q[i].d, exp_q[i].r, exp_q[i].c, exp_q[i].d);
      end
    end
  endtask

  task automatic test_random_gaps(input string name);
    bit ok, idle;
    sel = 2;
    fill_random(26, 26, 8);
    build_expected(26, 26, 8);
    start_frame();
    feed(676, 30, ok);
    wait_idle(100, idle);
    checks++;
    if (!ok || !idle || got_q.size() != 169 || done_cnt != 1) begin
      failures++;
      $display("FAIL %s_count fed=%b idle=%b outputs=%0d done_pulses=%0d want 1 1 169 1",
               name, ok, idle, got_q.size(), done_cnt);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].r !== exp_q[i].r || got_q[i].c !== exp_q[i].c || got_q[i].d !== exp_q[i].d) begin
        failures++;
        $display("FAIL %s_frame i=%0d got (%0d,%0d,%h) want (%0d,%0d,%h)", name, i,
                 got_q[i].r, got_q[i].c, got_q[i].d, exp_q[i].r, exp_q[i].c, exp_q[i].d);
      end
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    sel = 2;
    fill_random(26, 26, 8);
    start_frame();
    feed(26*11 + 7, 10, ok);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({ov, iready, bsy, dn, orow, ocol, od} !== '0) begin
        failures++;
        $display("FAIL midrst_state cyc=%0d got ov=%b ir=%b busy=%b row=%0d col=%0d data=%h want all zero",
                 i, ov, iready, bsy, orow, ocol, od);
      end
      @(posedge clk);
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    test_random_gaps("postrst");
  endtask

  initial begin
    sel = 0;
    do_reset();
    test_reset();
    test_ramp4x4();
    test_neg_window();
    test_odd_dims();
    test_backpressure();
    test_random_gaps("gaps");
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
